// File: rtl/ddr_rw_sched.sv
// DDR4 read/write data-phase scheduler: queues CAS commands with per-command due
// times, fires a one-cycle type strobe on each data slot and tracks burst occupancy.
//
// state  | meaning
// IDLE   | queue empty, data bus free
// WAIT   | commands queued, bus free, head not yet due
// DATA   | burst in progress on the data bus
module ddr_rw_sched #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 8,
    parameter int LAT_W = 6
) (
    input  logic                     CK_t,
    input  logic                     reset,
    input  logic                     cas_rdy,
    input  logic [2:0]               cas_req,
    input  logic [LAT_W-1:0]         CL,
    input  logic [LAT_W-1:0]         CWL,
    input  logic [LAT_W-1:0]         AL,
    input  logic [LAT_W-1:0]         RD_PRE,
    input  logic [LAT_W-1:0]         WR_PRE,
    input  logic [3:0]               BL,
    output logic                     rd_rdy,
    output logic                     wr_rdy,
    output logic                     rda_rdy,
    output logic                     wra_rdy,
    output logic                     data_idle,
    output logic                     rw_done,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic                     late_err,
    output logic                     ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int L_W   = LAT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t             state, state_n;
    logic [TS_W-1:0]    ts;

    logic [1:0]         req_type;
    logic [L_W-1:0]     lat_sum, lat_pre, lat;
    logic [TS_W-1:0]    due_in;
    logic [2:0]         beats_in;

    logic [1:0]         typ_mem   [DEPTH];
    logic [TS_W-1:0]    due_mem   [DEPTH];
    logic [2:0]         beats_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_n;

    logic [2:0]         beat_cnt, beat_cnt_n;
    logic [3:0]         strobe_q, strobe_n;
    logic               late_n, done_n;
    logic               full, push, pop;
    logic [TS_W-1:0]    head_diff;
    logic               head_due, head_on_time, bus_free_next, fire;

    // Latency and burst decode for the incoming command
    always_comb begin
        req_type = (cas_req > 3'd3) ? 2'd1 : cas_req[1:0];
        if (req_type[0]) begin
            lat_sum = {1'b0, CWL} + {1'b0, AL};
            lat_pre = {1'b0, WR_PRE};
        end else begin
            lat_sum = {1'b0, CL} + {1'b0, AL};
            lat_pre = {1'b0, RD_PRE};
        end
        lat      = (lat_sum < lat_pre + L_W'(2)) ? L_W'(2) : lat_sum - lat_pre;
        due_in   = ts + TS_W'(lat);
        beats_in = (BL < 4'd4) ? 3'd2 : BL[3:1];
    end

    // Decisions look one cycle ahead so strobes come straight out of flops
    always_comb begin
        full          = (count == CNT_W'(DEPTH));
        push          = cas_rdy && !full;
        pop           = |strobe_q;
        head_diff     = ts + TS_W'(1) - due_mem[rd_ptr];
        head_due      = !head_diff[TS_W-1];
        head_on_time  = (head_diff == '0);
        bus_free_next = (state != S_DATA) || (beat_cnt == 3'd1);
        fire          = (count != '0) && !pop && head_due && bus_free_next;
        count_n       = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        strobe_n   = 4'b0000;
        late_n     = 1'b0;
        done_n     = 1'b0;
        if (fire) begin
            state_n    = S_DATA;
            beat_cnt_n = beats_mem[rd_ptr];
            strobe_n   = 4'b0001 << typ_mem[rd_ptr];
            late_n     = !head_on_time;
        end else if (state == S_DATA && beat_cnt > 3'd1) begin
            beat_cnt_n = beat_cnt - 3'd1;
            done_n     = (beat_cnt == 3'd2);
        end else begin
            beat_cnt_n = 3'd0;
            state_n    = (count_n != '0) ? S_WAIT : S_IDLE;
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ts       <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat_cnt <= 3'd0;
            strobe_q <= 4'b0000;
            late_err <= 1'b0;
            rw_done  <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            state    <= state_n;
            ts       <= ts + TS_W'(1);
            count    <= count_n;
            beat_cnt <= beat_cnt_n;
            strobe_q <= strobe_n;
            late_err <= late_n;
            rw_done  <= done_n;
            ovf_err  <= cas_rdy && full;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Payload storage needs no reset; occupancy is governed by count
    always_ff @(posedge CK_t) begin
        if (push) begin
            typ_mem[wr_ptr]   <= req_type;
            due_mem[wr_ptr]   <= due_in;
            beats_mem[wr_ptr] <= beats_in;
        end
    end

    assign {wra_rdy, rda_rdy, wr_rdy, rd_rdy} = strobe_q;
    assign data_idle = (state != S_DATA);
    assign q_count   = count;
    assign q_full    = full;

endmodule

// File: tb/tb_ddr_rw_sched.sv
// Scoreboard bench for ddr_rw_sched: directed CAS sequences push expected strobes and
// burst ends; a negedge monitor pops and compares whenever the DUT reports one.
module tb_ddr_rw_sched;

    logic       CK_t = 1'b0;
    logic       reset = 1'b0;
    logic       cas_rdy = 1'b0;
    logic [2:0] cas_req = 3'd0;
    logic [5:0] CL = '0, CWL = '0, AL = '0, RD_PRE = '0, WR_PRE = '0;
    logic [3:0] BL = 4'd8;

    logic rd_rdy, wr_rdy, rda_rdy, wra_rdy, data_idle, rw_done, q_full, late_err, ovf_err;
    logic [2:0] q_count;
    logic b_rd_rdy, b_wr_rdy, b_rda_rdy, b_wra_rdy, b_data_idle, b_rw_done, b_q_full;
    logic b_late_err, b_ovf_err;
    logic [3:0] b_q_count;

    ddr_rw_sched #(.DEPTH(4), .TS_W(8), .LAT_W(6)) dut (
        .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE), .BL(BL),
        .rd_rdy(rd_rdy), .wr_rdy(wr_rdy), .rda_rdy(rda_rdy), .wra_rdy(wra_rdy),
        .data_idle(data_idle), .rw_done(rw_done), .q_count(q_count), .q_full(q_full),
        .late_err(late_err), .ovf_err(ovf_err)
    );

    // Narrow timestamp instance for the wrap case
    ddr_rw_sched #(.DEPTH(8), .TS_W(4), .LAT_W(6)) dut_w (
        .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .CL(CL), .CWL(CWL), .AL(AL), .RD_PRE(RD_PRE), .WR_PRE(WR_PRE), .BL(BL),
        .rd_rdy(b_rd_rdy), .wr_rdy(b_wr_rdy), .rda_rdy(b_rda_rdy), .wra_rdy(b_wra_rdy),
        .data_idle(b_data_idle), .rw_done(b_rw_done), .q_count(b_q_count), .q_full(b_q_full),
        .late_err(b_late_err), .ovf_err(b_ovf_err)
    );

    always #5 CK_t = ~CK_t;

    int cyc;
    always @(posedge CK_t or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        int t;
        int typ;
        int late;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CK_t) begin : monitor
        logic [3:0] strb;
        exp_t       e;
        if (!reset) begin
            strb = {wra_rdy, rda_rdy, wr_rdy, rd_rdy};
            if (strb != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_strobe: got %b expected none (cyc %0d)", strb, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_type", int'(strb), 1 << e.typ);
                    chk("strobe_ts", cyc, e.t);
                    chk("late_err", int'(late_err), e.late);
                end
            end else if (late_err) begin
                total++; bad++;
                $display("FAIL late_without_strobe: got 1 expected 0 (cyc %0d)", cyc);
            end
            if (rw_done) begin
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rw_done: got 1 expected 0 (cyc %0d)", cyc);
                end else begin
                    chk("rw_done_ts", cyc, done_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 500) begin
            @(posedge CK_t);
            #1;
            guard++;
        end
        if (cyc != n) begin
            total++; bad++;
            $display("FAIL wait_cyc: got %0d expected %0d", cyc, n);
        end
    endtask

    task automatic issue(input int req, input int cl, input int cwl, input int al,
                         input int rdp, input int wrp, input int bl);
        cas_rdy = 1'b1;
        cas_req = req[2:0];
        CL      = cl[5:0];
        CWL     = cwl[5:0];
        AL      = al[5:0];
        RD_PRE  = rdp[5:0];
        WR_PRE  = wrp[5:0];
        BL      = bl[3:0];
        @(posedge CK_t);
        #1;
        cas_rdy = 1'b0;
    endtask

    task automatic expect_strobe(input int t, input int typ, input int late);
        exp_t e;
        e.t = t; e.typ = typ; e.late = late;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cas_rdy = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge CK_t);
        reset = 1'b0;
    endtask

    task automatic end_test(input int n);
        wait_cyc(n);
        chk("pending_strobes", exp_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_data_idle", int'(data_idle), 1);
        chk("rst_q_count", int'(q_count), 0);
        chk("rst_q_full", int'(q_full), 0);
        chk("rst_strobes", int'({rd_rdy, wr_rdy, rda_rdy, wra_rdy, rw_done, late_err, ovf_err}), 0);

        // single read, L = 11 + 0 - 1 = 10
        do_reset();
        wait_cyc(5);
        expect_strobe(15, 0, 0); done_q.push_back(18);
        issue(0, 11, 9, 0, 1, 1, 8);
        chk("t1_q_count_after_accept", int'(q_count), 1);
        wait_cyc(14); chk("t1_idle_before", int'(data_idle), 1);
        wait_cyc(15); chk("t1_busy_beat1", int'(data_idle), 0);
                      chk("t1_q_count_strobe_cycle", int'(q_count), 1);
        wait_cyc(16); chk("t1_q_count_after_strobe", int'(q_count), 0);
        wait_cyc(18); chk("t1_busy_beat4", int'(data_idle), 0);
        wait_cyc(19); chk("t1_idle_after", int'(data_idle), 1);
        end_test(30);

        // seamless back-to-back reads
        do_reset();
        expect_strobe(15, 0, 0); expect_strobe(19, 0, 0);
        done_q.push_back(18); done_q.push_back(22);
        wait_cyc(5); issue(0, 11, 9, 0, 1, 1, 8);
        wait_cyc(9); issue(0, 11, 9, 0, 1, 1, 8);
        for (int i = 15; i <= 22; i++) begin
            wait_cyc(i);
            chk("t2_busy", int'(data_idle), 0);
        end
        wait_cyc(23); chk("t2_idle_after", int'(data_idle), 1);
        end_test(30);

        // write due while read burst holds the bus
        do_reset();
        expect_strobe(15, 0, 0); expect_strobe(19, 1, 1);
        done_q.push_back(18); done_q.push_back(22);
        wait_cyc(5); issue(0, 11, 9, 0, 1, 1, 8);
        wait_cyc(6); issue(1, 11, 9, 0, 1, 1, 8);
        end_test(30);

        // overflow with DEPTH=4, L = 21 + 0 - 1 = 20
        do_reset();
        expect_strobe(25, 0, 0); expect_strobe(29, 0, 1);
        expect_strobe(33, 0, 1); expect_strobe(37, 0, 1);
        done_q.push_back(28); done_q.push_back(32); done_q.push_back(36); done_q.push_back(40);
        for (int i = 0; i < 5; i++) begin
            wait_cyc(5 + i);
            if (i == 3) begin
                chk("t4_not_full", int'(q_full), 0);
                chk("t4_q_count_3", int'(q_count), 3);
            end
            if (i == 4) begin
                chk("t4_full", int'(q_full), 1);
                chk("t4_q_count_4", int'(q_count), 4);
                chk("t4_no_ovf_yet", int'(ovf_err), 0);
            end
            issue(0, 21, 9, 0, 1, 1, 8);
        end
        chk("t4_ovf_err", int'(ovf_err), 1);
        chk("t4_q_count_held", int'(q_count), 4);
        wait_cyc(11); chk("t4_ovf_one_cycle", int'(ovf_err), 0);
        end_test(50);

        // RDA across timestamp wrap on the TS_W=4 instance, L = 6 + 0 - 1 = 5
        do_reset();
        expect_strobe(19, 2, 0); done_q.push_back(20);
        wait_cyc(14); issue(2, 6, 9, 0, 1, 1, 4);
        for (int i = 15; i <= 18; i++) begin
            wait_cyc(i);
            chk("t5_wrap_no_early", int'({b_wra_rdy, b_rda_rdy, b_wr_rdy, b_rd_rdy}), 0);
        end
        wait_cyc(19);
        chk("t5_wrap_strobe", int'({b_wra_rdy, b_rda_rdy, b_wr_rdy, b_rd_rdy}), 4);
        chk("t5_wrap_late", int'(b_late_err), 0);
        chk("t5_wrap_busy", int'(b_data_idle), 0);
        wait_cyc(20);
        chk("t5_wrap_strobe_gone", int'({b_wra_rdy, b_rda_rdy, b_wr_rdy, b_rd_rdy}), 0);
        chk("t5_wrap_done", int'(b_rw_done), 1);
        wait_cyc(21); chk("t5_wrap_idle", int'(b_data_idle), 1);
        end_test(30);

        // reset during beat 2 flushes the burst and the queued read
        do_reset();
        expect_strobe(15, 0, 0);
        wait_cyc(5); issue(0, 11, 9, 0, 1, 1, 8);
        wait_cyc(8); issue(0, 11, 9, 0, 1, 1, 8);
        wait_cyc(15); chk("t6_q_count_2", int'(q_count), 2);
        wait_cyc(16);
        reset = 1'b1;
        #1;
        chk("t6_rst_idle", int'(data_idle), 1);
        chk("t6_rst_q_count", int'(q_count), 0);
        chk("t6_rst_q_full", int'(q_full), 0);
        repeat (2) @(negedge CK_t);
        reset = 1'b0;
        wait_cyc(20);
        chk("t6_q_count_after", int'(q_count), 0);
        end_test(22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
